deserializer: RTL and testbench

Receive-side counterpart of the NV Controller byte serializer. It samples a single serial data line LSB-first and reassembles one `DATA_WIDTH`-bit word, then presents the word with a one-cycle valid strobe and a sticky done flag. It shares the serializer's `start` gating and clock, so the two connect back-to-back for loopback and for the controller-to-peripheral link on the VC707.

---
 rtl/nv_link_pkg.sv | 22 ++
 rtl/deserializer.sv | 131 +++++++++++++
 tb/tb_deserializer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nv_link_pkg.sv
// ----------------------------------------------------------------------------
// nv_link_pkg
//
// Shared definitions for the NV Controller serial link. The serializer and
// the deserializer both import this package, which keeps the default word
// width and the receiver state encoding in one place.
//
// Contents:
//   NV_WORD_WIDTH  default link word width in bits
//   deser_state_t  deserializer state encoding (2'd3 is unused)
// ----------------------------------------------------------------------------
package nv_link_pkg;

   localparam int unsigned NV_WORD_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } deser_state_t;

endpackage

// File: rtl/deserializer.sv
// ----------------------------------------------------------------------------
// deserializer
//
// Receive side of the NV Controller serial link. The block samples
// serial_data_in LSB-first and assembles one DATA_WIDTH-bit word. It then
// presents the word with a one-cycle data_valid pulse and a sticky
// done_receive flag. The serializer's start net also drives this block, so
// the two can be wired back-to-back.
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous active-high reset; reset wins over start
//   start           transmitter advance strobe (same net as serializer start)
//   serial_data_in  serial bit stream, LSB first
//   data_out        assembled word; holds until the next word or reset
//   data_valid      one-cycle pulse in the cycle data_out updates
//   done_receive    sticky word-complete flag, cleared only by reset
//   busy            high while a word is partially received
//
// DATA_WIDTH legal range is 2..32.
// ----------------------------------------------------------------------------
module deserializer
   import nv_link_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = NV_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  serial_data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  done_receive,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   // Registered state
   logic                  start_q;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   deser_state_t          state;

   // Next-state values
   logic [CNT_W-1:0]      bit_cnt_d;
   logic [DATA_WIDTH-1:0] shreg_d;
   deser_state_t          state_d;
   logic [DATA_WIDTH-1:0] data_out_d;
   logic                  data_valid_d;
   logic                  done_receive_d;

   // The transmitter drives a bit on the edge where start is high. That bit
   // stays stable until the transmitter's next advancing edge. Sampling one
   // edge later therefore sees it, even when start drops in between.
   logic [DATA_WIDTH-1:0] shifted;
   assign shifted = {serial_data_in, shreg[DATA_WIDTH-1:1]};

   always_comb begin
      state_d        = state;
      bit_cnt_d      = bit_cnt;
      shreg_d        = shreg;
      data_out_d     = data_out;
      data_valid_d   = 1'b0;
      done_receive_d = done_receive;

      case (state)
         IDLE: begin
            if (start_q) begin
               shreg_d   = shifted;
               bit_cnt_d = bit_cnt + 1'b1;
               state_d   = RECV;
            end
         end

         RECV: begin
            // When start_q is low, every register holds. A gap can be any
            // length.
            if (start_q) begin
               shreg_d = shifted;
               if (bit_cnt == LAST_CNT) begin
                  data_out_d     = shifted;
                  data_valid_d   = 1'b1;
                  done_receive_d = 1'b1;
                  bit_cnt_d      = '0;
                  state_d        = DONE;
               end else begin
                  bit_cnt_d = bit_cnt + 1'b1;
               end
            end
         end

         DONE: begin
            // Terminal until reset; later samples are ignored.
         end

         default: begin
            // Unused encoding: go back to a clean idle.
            state_d   = IDLE;
            bit_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // Forcing start_q low here means an edge with reset and start both
         // high is never counted, which matches the serializer.
         start_q      <= 1'b0;
         bit_cnt      <= '0;
         shreg        <= '0;
         state        <= IDLE;
         data_out     <= '0;
         data_valid   <= 1'b0;
         done_receive <= 1'b0;
         busy         <= 1'b0;
      end else begin
         start_q      <= start;
         bit_cnt      <= bit_cnt_d;
         shreg        <= shreg_d;
         state        <= state_d;
         data_out     <= data_out_d;
         data_valid   <= data_valid_d;
         done_receive <= done_receive_d;
         // busy is registered from the next state, so it matches state RECV.
         busy         <= (state_d == RECV);
      end
   end

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         serial_data_in;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         done_receive;
   logic         busy;

   always #5 clk = ~clk;

   deserializer #(.DATA_WIDTH(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .serial_data_in (serial_data_in),
      .data_out       (data_out),
      .data_valid     (data_valid),
      .done_receive   (done_receive),
      .busy           (busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Serializer model. On each edge where start is high, it drives the next
   // LSB-first bit. It raises done_tx on the edge after its last advancing
   // edge.
   logic [7:0] tx_word = 8'h00;
   logic [3:0] tx_cnt;
   logic       tx_sdo;
   logic       tx_adv_q;
   logic       done_tx;

   always @(posedge clk) begin
      if (reset) begin
         tx_cnt   <= 4'd0;
         tx_sdo   <= 1'b0;
         tx_adv_q <= 1'b0;
         done_tx  <= 1'b0;
      end else begin
         tx_adv_q <= start;
         if (start && tx_cnt < 4'd8) begin
            tx_sdo <= tx_word[tx_cnt[2:0]];
            tx_cnt <= tx_cnt + 4'd1;
         end
         if (tx_adv_q && tx_cnt == 4'd8) done_tx <= 1'b1;
      end
   end

   logic ovr_en  = 1'b0;
   logic ovr_bit = 1'b0;
   assign serial_data_in = ovr_en ? ovr_bit : tx_sdo;

   typedef struct {
      logic [7:0] word;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   logic lb_mode = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Monitor: pops one expected word for every data_valid pulse.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (data_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("data_out", 32'(data_out), 32'(e.word));
            chk("valid_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (lb_mode) chk("done_align", 32'(done_receive), 32'(done_tx));
   end

   // Inputs change on the falling edge; each step is one rising edge.
   task automatic step(input logic st);
      start = st;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
   endtask

   // Sends one word. ga/gb: bit index after which a gap of la/lb edges is
   // inserted (-1 = no gap).
   task automatic run_frame(input logic [7:0] w, input int ga, input int la,
                            input int gb, input int lb);
      exp_t e;
      tx_word = w;
      e.word  = w;
      e.cyc   = cyc + 9 + (ga >= 0 ? la : 0) + (gb >= 0 ? lb : 0);
      exp_q.push_back(e);
      for (int k = 0; k < 8; k++) begin
         step(1'b1);
         if (k == ga) begin
            for (int g = 0; g < la; g++) begin
               step(1'b0);
               chk("busy_gap", 32'(busy), 32'd1);
            end
         end
         if (k == gb) begin
            for (int g = 0; g < lb; g++) begin
               step(1'b0);
               chk("busy_gap", 32'(busy), 32'd1);
            end
         end
      end
      step(1'b0);
      step(1'b0);
      chk("done_after_frame", 32'(done_receive), 32'd1);
      chk("busy_after_frame", 32'(busy), 32'd0);
      chk("data_hold", 32'(data_out), 32'(w));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      step(1'b0);
      step(1'b0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_done", 32'(done_receive), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      // Gapless frame.
      run_frame(8'h2D, -1, 0, -1, 0);

      // Post-done bits are ignored.
      ovr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ovr_bit = i[0];
         step(1'b1);
         chk("postdone_data", 32'(data_out), 32'h2D);
         chk("postdone_done", 32'(done_receive), 32'd1);
      end
      ovr_en = 1'b0;

      // Gapped frame: 3 low edges after bit 2, 1 after bit 6.
      do_reset();
      run_frame(8'hA5, 2, 3, 6, 1);

      // Mid-frame reset.
      do_reset();
      tx_word = 8'hFF;
      for (int i = 0; i < 4; i++) step(1'b1);
      step(1'b0);
      chk("partial_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      chk("abort_data_out", 32'(data_out), 32'd0);
      chk("abort_done", 32'(done_receive), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      run_frame(8'h3C, -1, 0, -1, 0);

      // Reset and start high on the same edge.
      reset = 1'b1;
      step(1'b1);
      reset = 1'b0;
      run_frame(8'h81, -1, 0, -1, 0);

      // Loopback with random bytes.
      for (int n = 0; n < 20; n++) begin
         do_reset();
         lb_mode = 1'b1;
         run_frame(8'($urandom_range(0, 255)), -1, 0, -1, 0);
         lb_mode = 1'b0;
      end

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
